aes_block_loader: RTL

//   Byte-serial input stage directly upstream of AES_Encrypt. Assembles 16 input bytes

---
 rtl/aes_block_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/aes_block_loader.sv
// Byte-serial loader feeding AES_Encrypt: packs 16 bytes (MSB first) into a plaintext
// block offered with valid/ready, or into the cipher key, which is only ever replaced whole.
module aes_block_loader #(
    parameter int                        BLOCK_BYTES = 16,
    parameter logic [8*BLOCK_BYTES-1:0]  KEY_RESET   = 128'h000102030405060708090a0b0c0d0e0f
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  byte_in,
    input  logic                        byte_valid,
    input  logic                        load_key,
    input  logic                        flush,
    output logic                        byte_ready,
    output logic [8*BLOCK_BYTES-1:0]    block_out,
    output logic                        block_valid,
    input  logic                        block_ready,
    output logic [8*BLOCK_BYTES-1:0]    key_out,
    output logic                        key_loaded,
    output logic [3:0]                  fill_count
);

    localparam int         W    = 8 * BLOCK_BYTES;
    localparam logic [3:0] LAST = 4'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_q,      state_d;
    logic [3:0]     fill_count_q, fill_count_d;
    logic [W-1:0]   sreg_q,       sreg_d;
    logic           mode_q,       mode_d;
    logic [W-1:0]   block_out_q,  block_out_d;
    logic [W-1:0]   key_out_q,    key_out_d;
    logic           key_loaded_q, key_loaded_d;

    logic           accept;
    logic [W-1:0]   shifted;

    assign byte_ready = (state_q != HOLD);
    assign accept     = byte_valid && byte_ready && !flush;
    assign shifted    = {sreg_q[W-9:0], byte_in};

    always_comb begin
        state_d      = state_q;
        fill_count_d = fill_count_q;
        sreg_d       = sreg_q;
        mode_d       = mode_q;
        block_out_d  = block_out_q;
        key_out_d    = key_out_q;
        key_loaded_d = key_loaded_q;

        // flush wins over both byte acceptance and the block handshake
        if (flush) begin
            state_d      = IDLE;
            fill_count_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sreg_d       = shifted;
                        mode_d       = load_key;
                        fill_count_d = 4'd1;
                        state_d      = FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        sreg_d = shifted;
                        if (fill_count_q == LAST) begin
                            fill_count_d = 4'd0;
                            if (mode_q) begin
                                key_out_d    = shifted;
                                key_loaded_d = 1'b1;
                                state_d      = IDLE;
                            end else begin
                                block_out_d = shifted;
                                state_d     = HOLD;
                            end
                        end else begin
                            fill_count_d = fill_count_q + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (block_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    fill_count_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fill_count_q <= 4'd0;
            sreg_q       <= '0;
            mode_q       <= 1'b0;
            block_out_q  <= '0;
            key_out_q    <= KEY_RESET;
            key_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_count_q <= fill_count_d;
            sreg_q       <= sreg_d;
            mode_q       <= mode_d;
            block_out_q  <= block_out_d;
            key_out_q    <= key_out_d;
            key_loaded_q <= key_loaded_d;
        end
    end

    assign block_out   = block_out_q;
    assign block_valid = (state_q == HOLD);
    assign key_out     = key_out_q;
    assign key_loaded  = key_loaded_q;
    assign fill_count  = fill_count_q;

endmodule
